// File: rtl/instr_loader_if.sv
// Byte-stream input, load control and instruction-RAM write port of the
// program loader, bundled so the host side and the loader share one bus.
interface instr_loader_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
);
    logic                  start;
    logic [ADDR_WIDTH:0]   word_count;
    logic                  in_valid;
    logic [7:0]            in_data;
    logic                  in_ready;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic                  busy;
    logic                  done;
    logic                  cpu_hold;

    // Host / debug link side: issues loads and supplies bytes.
    modport master (
        output start, word_count, in_valid, in_data,
        input  in_ready, mem_we, mem_addr, mem_wdata, busy, done, cpu_hold
    );

    // Loader side.
    modport slave (
        input  start, word_count, in_valid, in_data,
        output in_ready, mem_we, mem_addr, mem_wdata, busy, done, cpu_hold
    );
endinterface

// File: rtl/instr_loader.sv
// Program loader: assembles a little-endian byte stream into 32-bit words,
// writes them to instruction memory from address 0 upward and keeps the CPU
// held in reset until a load has completed.
module instr_loader #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
) (
    input logic          clk,
    input logic          reset,
    instr_loader_if.slave bus
);
    localparam int CNT_W = ADDR_WIDTH + 1;
    localparam logic [CNT_W-1:0] MAX_WORDS = CNT_W'(1) << ADDR_WIDTH;

    typedef enum logic [1:0] {IDLE, RECV, WRITE, DONE} state_t;

    state_t                state, state_nxt;
    logic [CNT_W-1:0]      words_left;
    logic [ADDR_WIDTH-1:0] addr_cnt;
    logic [1:0]            byte_cnt;
    logic [23:0]           asm_q;
    logic [ADDR_WIDTH-1:0] mem_addr_q;
    logic [DATA_WIDTH-1:0] mem_wdata_q;
    logic                  cpu_hold_q;
    logic                  accept;
    logic                  last_byte;
    logic [CNT_W-1:0]      count_clamped;

    // Requests above the memory size are truncated to a full-memory load.
    function automatic logic [CNT_W-1:0] clamp_count(input logic [CNT_W-1:0] c);
        return (c > MAX_WORDS) ? MAX_WORDS : c;
    endfunction

    assign count_clamped = clamp_count(bus.word_count);
    assign accept        = (state == RECV) && bus.in_valid;
    assign last_byte     = accept && (byte_cnt == 2'd3);

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state selection.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = (count_clamped == '0) ? DONE : RECV;
            RECV:    if (last_byte) state_nxt = WRITE;
            WRITE:   state_nxt = (words_left == CNT_W'(1)) ? DONE : RECV;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Counters, byte assembly and the registered write port; the finished
    // word and its address are captured on the last byte so they hold their
    // values after the write cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            words_left  <= '0;
            addr_cnt    <= '0;
            byte_cnt    <= '0;
            asm_q       <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            cpu_hold_q  <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        words_left <= count_clamped;
                        addr_cnt   <= '0;
                        byte_cnt   <= '0;
                        cpu_hold_q <= 1'b1;
                    end
                end
                RECV: begin
                    if (accept) begin
                        byte_cnt <= byte_cnt + 2'd1;
                        case (byte_cnt)
                            2'd0: asm_q[7:0]   <= bus.in_data;
                            2'd1: asm_q[15:8]  <= bus.in_data;
                            2'd2: asm_q[23:16] <= bus.in_data;
                            default: begin
                                mem_wdata_q <= {bus.in_data, asm_q};
                                mem_addr_q  <= addr_cnt;
                            end
                        endcase
                    end
                end
                WRITE: begin
                    addr_cnt   <= addr_cnt + 1'b1;
                    words_left <= words_left - 1'b1;
                    byte_cnt   <= '0;
                end
                DONE: cpu_hold_q <= 1'b0;
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = (state == RECV);
    assign bus.mem_we    = (state == WRITE);
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.busy      = (state != IDLE);
    assign bus.done      = (state == DONE);
    assign bus.cpu_hold  = cpu_hold_q;
endmodule

// File: tb/tb_instr_loader.sv
// Bench for instr_loader: cycle tables for exact timing, plus randomized
// loads compared against a word-list model built from the byte stream.
module tb_instr_loader;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    instr_loader_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) bus();

    instr_loader #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic       v;
        logic [7:0] d;
        logic       rdy;
        logic       we;
        logic       dn;
        logic       bsy;
        logic       hold;
    } vec_t;

    typedef struct {
        logic [7:0]  a;
        logic [31:0] d;
    } wr_t;

    vec_t tbl[$];
    wr_t  got[$];
    int   done_cnt = 0;
    int   viol = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Observe the write port, done pulses and the ready invariant.
    always @(negedge clk) begin
        if (reset) begin
            if (bus.mem_we) got.push_back('{a: bus.mem_addr, d: bus.mem_wdata});
            if (bus.done) done_cnt++;
            if (bus.in_ready && (bus.mem_we || bus.done || !bus.busy)) viol++;
        end
    end

    task automatic do_start(input int n);
        bus.start = 1'b1;
        bus.word_count = 9'(n);
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    task automatic apply_tbl(input string nm);
        foreach (tbl[i]) begin
            bus.in_valid = tbl[i].v;
            bus.in_data  = tbl[i].d;
            @(negedge clk);
            chk($sformatf("%s[%0d].in_ready", nm, i), 32'(bus.in_ready), 32'(tbl[i].rdy));
            chk($sformatf("%s[%0d].mem_we", nm, i),   32'(bus.mem_we),   32'(tbl[i].we));
            chk($sformatf("%s[%0d].done", nm, i),     32'(bus.done),     32'(tbl[i].dn));
            chk($sformatf("%s[%0d].busy", nm, i),     32'(bus.busy),     32'(tbl[i].bsy));
            chk($sformatf("%s[%0d].cpu_hold", nm, i), 32'(bus.cpu_hold), 32'(tbl[i].hold));
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
    endtask

    // Offer one byte, with optional idle cycles before it, until accepted.
    task automatic push_byte(input logic [7:0] b, input int stall_pct);
        int  guard = 0;
        int  idle = 0;
        bit  acc = 0;
        while (idle < 6 && $urandom_range(99) < stall_pct) begin
            bus.in_valid = 1'b0;
            @(posedge clk); #1;
            idle++;
        end
        bus.in_data = b;
        while (!acc && guard < 50) begin
            bus.in_valid = 1'b1;
            @(negedge clk);
            acc = bus.in_ready;
            @(posedge clk); #1;
            guard++;
        end
        bus.in_valid = 1'b0;
        if (!acc) chk("byte_accept_timeout", 32'(acc), 32'd1);
    endtask

    // One complete load, checked against the expected word list.
    task automatic run_load(input string nm, input int n, input int stall, input bit mid_start);
        int nn = (n > 256) ? 256 : n;
        logic [7:0] bytes[$];
        logic [31:0] w;
        int bad = 0;
        got.delete();
        done_cnt = 0;
        viol = 0;
        for (int i = 0; i < 4 * nn; i++) bytes.push_back(8'($urandom_range(255)));
        do_start(n);
        for (int i = 0; i < 4 * nn; i++) begin
            if (mid_start && i == 6) begin
                bus.word_count = 9'd1;
                bus.start = 1'b1;
                @(posedge clk); #1;
                bus.start = 1'b0;
            end
            push_byte(bytes[i], stall);
        end
        for (int t = 0; t < 12 && done_cnt == 0; t++) @(negedge clk);
        chk({nm, ".done_seen"}, 32'(done_cnt > 0), 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        chk({nm, ".cpu_hold_after"}, 32'(bus.cpu_hold), 32'd0);
        chk({nm, ".busy_after"}, 32'(bus.busy), 32'd0);
        chk({nm, ".done_count"}, 32'(done_cnt), 32'd1);
        chk({nm, ".write_count"}, 32'(got.size()), 32'(nn));
        chk({nm, ".ready_outside_recv"}, 32'(viol), 32'd0);
        if (got.size() == nn) begin
            for (int i = 0; i < nn; i++) begin
                w = {bytes[4*i+3], bytes[4*i+2], bytes[4*i+1], bytes[4*i]};
                if (got[i].a !== 8'(i) || got[i].d !== w) begin
                    if (bad < 4)
                        $display("FAIL %s.word[%0d] actual=%h@%h required=%h@%h",
                                 nm, i, got[i].d, got[i].a, w, 8'(i));
                    bad++;
                end
            end
            chk({nm, ".bad_words"}, 32'(bad), 32'd0);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        bus.start = 1'b0;
        bus.word_count = '0;
        bus.in_valid = 1'b0;
        bus.in_data = '0;

        // Reset values while held and after release.
        #23;
        chk("rst.in_ready", 32'(bus.in_ready), 32'd0);
        chk("rst.mem_we", 32'(bus.mem_we), 32'd0);
        chk("rst.mem_addr", 32'(bus.mem_addr), 32'd0);
        chk("rst.mem_wdata", bus.mem_wdata, 32'd0);
        chk("rst.busy", 32'(bus.busy), 32'd0);
        chk("rst.done", 32'(bus.done), 32'd0);
        chk("rst.cpu_hold", 32'(bus.cpu_hold), 32'd1);
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rel.busy", 32'(bus.busy), 32'd0);
        chk("rel.mem_we", 32'(bus.mem_we), 32'd0);
        chk("rel.cpu_hold", 32'(bus.cpu_hold), 32'd1);
        @(posedge clk); #1;

        // Single word, back-to-back bytes: write in cycle 5, done in 6.
        tbl.delete();
        tbl.push_back('{1'b1, 8'h13, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1});
        tbl.push_back('{1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1});
        tbl.push_back('{1'b1, 8'h10, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1});
        tbl.push_back('{1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1});
        tbl.push_back('{1'b1, 8'hEE, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1});
        tbl.push_back('{1'b1, 8'hEE, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1});
        tbl.push_back('{1'b1, 8'hEE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
        got.delete();
        do_start(1);
        apply_tbl("single");
        chk("single.writes", 32'(got.size()), 32'd1);
        if (got.size() == 1) begin
            chk("single.addr", 32'(got[0].a), 32'd0);
            chk("single.wdata", got[0].d, 32'h00100013);
        end
        chk("single.wdata_stable", bus.mem_wdata, 32'h00100013);

        // Zero-length load: done the cycle after start, no write.
        tbl.delete();
        tbl.push_back('{1'b1, 8'h55, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1});
        tbl.push_back('{1'b1, 8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
        got.delete();
        do_start(0);
        apply_tbl("zero");
        chk("zero.writes", 32'(got.size()), 32'd0);

        // Stalled stream and other randomized loads.
        run_load("stall3", 3, 50, 1'b0);
        for (int k = 0; k < 4; k++)
            run_load($sformatf("rand%0d", k), int'($urandom_range(1, 8)), int'($urandom_range(0, 70)), 1'b0);
        run_load("zero_rl", 0, 0, 1'b0);

        // Start pulsed mid-load must not change the count.
        run_load("ignored_start", 4, 20, 1'b1);

        // Oversized count clamps to a full-memory load.
        run_load("full300", 300, 0, 1'b0);

        // Reset two bytes into word 1 of a 4-word load.
        got.delete();
        do_start(4);
        for (int i = 0; i < 6; i++) push_byte(8'(8'hA0 + i), 0);
        #2 reset = 1'b0;
        #1;
        chk("abort.busy", 32'(bus.busy), 32'd0);
        chk("abort.in_ready", 32'(bus.in_ready), 32'd0);
        chk("abort.cpu_hold", 32'(bus.cpu_hold), 32'd1);
        chk("abort.mem_we", 32'(bus.mem_we), 32'd0);
        chk("abort.writes", 32'(got.size()), 32'd1);
        if (got.size() == 1) chk("abort.word0", got[0].d, 32'hA3A2A1A0);
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("abort.idle_busy", 32'(bus.busy), 32'd0);
        chk("abort.idle_hold", 32'(bus.cpu_hold), 32'd1);
        @(posedge clk); #1;
        run_load("after_abort", 1, 0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/instr_loader.md
# instr_loader

Program loader that fills the instruction memory read by the fetch unit. Accepts a byte stream over a valid/ready handshake, assembles little-endian 32-bit instruction words, and writes them to consecutive instruction-memory addresses starting at 0. Holds the CPU in reset through `cpu_hold` until a load completes. Sits between the host/debug byte link and the instruction RAM write port.

## Interface
- `ADDR_WIDTH`, 8, instruction-memory word address width; matches the fetch PC width.
- `DATA_WIDTH`, 32, instruction word width; fixed at 32, 4 bytes per word.

- `clk` input 1: single clock; all state on the rising edge.
- `reset` input 1: asynchronous, active-low; clears all state immediately.
- `start` input 1: request a load; sampled only in IDLE.
- `word_count` input ADDR_WIDTH+1: number of words to load, sampled with `start`; 0..256 legal, 257..511 clamp to 256.
- `in_valid` input 1: byte available on `in_data`.
- `in_data` input 8: stream byte.
- `in_ready` output 1: loader accepts a byte this cycle.
- `mem_we` output 1: instruction-memory write strobe, one cycle per word.
- `mem_addr` output ADDR_WIDTH: write word address.
- `mem_wdata` output 32: write word.
- `busy` output 1: high in RECV, WRITE and DONE.
- `done` output 1: one-cycle pulse when a load finishes.
- `cpu_hold` output 1: high holds the fetch unit/CPU in reset.

## Operation
- FSM states: IDLE, RECV, WRITE, DONE.
- IDLE: `in_ready`=0, `busy`=0. If `start`=1, latch the clamped `word_count` into `words_left`, clear `addr_cnt` and `byte_cnt`, set `cpu_hold`=1. If the latched count is 0, go to DONE; otherwise go to RECV.
- RECV: `in_ready`=1. A byte is accepted when `in_valid && in_ready`. Byte k (k=0..3) goes to bits [8k+7:8k] of the assembly register. `byte_cnt` increments per accepted byte. After the 4th byte, go to WRITE. No byte is accepted on cycles where `in_valid`=0; the state holds.
- WRITE: `in_ready`=0, `mem_we`=1, `mem_addr`=`addr_cnt`, `mem_wdata`=assembled word. On exit, `addr_cnt`+1 (wraps mod 2^ADDR_WIDTH, reachable only at count 256), `words_left`-1, `byte_cnt`=0. If `words_left` was 1, go to DONE; otherwise go to RECV.
- DONE: `done`=1 for exactly this cycle, `cpu_hold` cleared at exit. Go to IDLE.
- `start` outside IDLE is ignored. `in_valid` outside RECV is ignored and nothing is consumed.
- `mem_addr` and `mem_wdata` come directly from registers. Their value outside WRITE is don't-care to memory but stays stable (last value).

## Timing
- Reset values: `in_ready`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `busy`=0, `done`=0, `cpu_hold`=1, state=IDLE.
- `cpu_hold` is 1 out of reset and remains 1 until the first completed load. It re-asserts the cycle after each accepted `start`.
- With `start` sampled at edge 0, RECV is active from cycle 1.
- Best-case throughput is 5 cycles per word: 4 accept cycles plus 1 WRITE cycle.
- The last WRITE is followed by DONE on the next cycle. `cpu_hold`=0 from the cycle after DONE.
- A zero-length load runs start → DONE on the next cycle → IDLE with no `mem_we`.
- Reset asserted mid-load: FSM returns to IDLE immediately. A partial word is discarded and never written. `cpu_hold`=1. Already-written words are not rolled back.

## Test plan
- Reset: hold `reset`=0 then release → all outputs at reset values, `cpu_hold`=1, no `mem_we`.
- Single word: `start`, `word_count`=1, bytes 0x13,0x00,0x10,0x00 back-to-back → one `mem_we` at `mem_addr`=0 with `mem_wdata`=0x00100013, 5 cycles after start; `done` next cycle; `cpu_hold`=0 after.
- Stalled stream: `word_count`=3, `in_valid` toggled randomly → writes to addresses 0,1,2 with correct words; `in_ready` never high outside RECV; no bytes lost or duplicated.
- Zero and full: `word_count`=0 → `done` one cycle after start, no writes. `word_count`=300 → exactly 256 writes at addresses 0..255, then `done`.
- Abort: reset asserted after 2 bytes of word 1 of a 4-word load → no write for the partial word, FSM in IDLE, `cpu_hold`=1. A new load of 1 word then writes address 0.
- Ignored start: `start` pulsed mid-load with a different `word_count` → original count honoured, single `done`.
